// File: rtl/des_rx_160.sv
// des_rx_160: serial-to-byte deserializer with sync-word frame alignment.
// Hunts for SYNC_WORD in an LSB-first bit stream, verifies LOCK_COUNT
// correctly spaced repeats, then emits the data bytes of every frame with
// a one-cycle byte_valid strobe. LOSS_COUNT consecutive missed syncs drop
// the link back to hunting.
// Optional build macro DES_RX_160_ERRCNT_EN adds an 8-bit saturating
// sync_err_cnt output counting missed syncs and failed verifications.
module des_rx_160 #(
    parameter logic [7:0] SYNC_WORD  = 8'hBC,
    parameter int         FRAME_LEN  = 16,
    parameter int         LOCK_COUNT = 3,
    parameter int         LOSS_COUNT = 4
) (
    input  logic       clock_160,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       sof,
    output logic       locked
`ifdef DES_RX_160_ERRCNT_EN
    ,
    output logic [7:0] sync_err_cnt
`endif
);

    localparam int IDX_W   = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q;
    logic [7:0]         window_q;
    logic [2:0]         bit_cnt_q;
    logic [IDX_W-1:0]   byte_idx_q;
    logic [MATCH_W-1:0] match_cnt_q;
    logic [MISS_W-1:0]  miss_cnt_q;
    logic [7:0]         byte_out_q;
    logic               byte_valid_q;
    logic               sof_q;
    logic               locked_q;

    logic [7:0]         window_d;
    logic [IDX_W-1:0]   byte_idx_d;
    logic               boundary;
    logic               sync_hit;

    // Next window, frame-index wrap and byte-boundary / sync decode.
    always_comb begin
        // NOTE: every always_comb output gets an unconditional default so no latch can be inferred.
        window_d   = {bit_in, window_q[7:1]};
        byte_idx_d = byte_idx_q + IDX_W'(1);
        if (byte_idx_q == IDX_W'(FRAME_LEN - 1)) begin
            byte_idx_d = '0;
        end
        boundary = (bit_cnt_q == 3'd7);
        sync_hit = (window_d == SYNC_WORD);
    end

    // Alignment FSM: hunt, verify spacing, then deliver data bytes while locked.
    always_ff @(posedge clock_160) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= HUNT;
            window_q     <= '0;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            match_cnt_q  <= '0;
            miss_cnt_q   <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            if (bit_valid) begin
                window_q <= window_d;
                case (state_q)
                    HUNT: begin
                        if (sync_hit) begin
                            bit_cnt_q   <= '0;
                            byte_idx_q  <= IDX_W'(1);
                            match_cnt_q <= MATCH_W'(1);
                            if (LOCK_COUNT == 1) begin
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                                miss_cnt_q <= '0;
                            end else begin
                                state_q <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (!boundary) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else begin
                            bit_cnt_q  <= '0;
                            byte_idx_q <= byte_idx_d;
                            if (byte_idx_q == '0) begin
                                if (sync_hit) begin
                                    match_cnt_q <= match_cnt_q + MATCH_W'(1);
                                    if (match_cnt_q == MATCH_W'(LOCK_COUNT - 1)) begin
                                        state_q    <= LOCKED;
                                        locked_q   <= 1'b1;
                                        miss_cnt_q <= '0;
                                    end
                                end else begin
                                    state_q     <= HUNT;
                                    match_cnt_q <= '0;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        if (!boundary) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else begin
                            bit_cnt_q  <= '0;
                            byte_idx_q <= byte_idx_d;
                            if (byte_idx_q != '0) begin
                                byte_out_q   <= window_d;
                                byte_valid_q <= 1'b1;
                                sof_q        <= (byte_idx_q == IDX_W'(1));
                            end else if (sync_hit) begin
                                miss_cnt_q <= '0;
                            end else if (miss_cnt_q == MISS_W'(LOSS_COUNT - 1)) begin
                                state_q     <= HUNT;
                                locked_q    <= 1'b0;
                                miss_cnt_q  <= '0;
                                match_cnt_q <= '0;
                            end else begin
                                miss_cnt_q <= miss_cnt_q + MISS_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                    end
                endcase
            end
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign sof        = sof_q;
    assign locked     = locked_q;

`ifdef DES_RX_160_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic       err_event;

    // A sync slot that fails while verifying or locked is one error.
    always_comb begin
        err_event = bit_valid && boundary && (byte_idx_q == '0) && !sync_hit &&
                    ((state_q == VERIFY) || (state_q == LOCKED));
    end

    // Saturating error counter, cleared only by reset.
    always_ff @(posedge clock_160) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (err_event && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign sync_err_cnt = err_cnt_q;
`endif

endmodule
